// File: rtl/control_itf.sv
// Pipeline control word driven by the hazard controller: forwarding selects
// plus per-stage pipe load / pipe reset strobes.
package control_itf;

   typedef struct packed {
      fwdmux::fwdmux_sel_t rs1mux_sel;
      fwdmux::fwdmux_sel_t rs2mux_sel;
      logic                pipe_load_ifid;
      logic                pipe_load_idex;
      logic                pipe_load_exmem;
      logic                pipe_load_memwb;
      logic                pipe_rst_ifid;
      logic                pipe_rst_idex;
      logic                pipe_rst_exmem;
      logic                pipe_rst_memwb;
   } control;

endpackage

// File: rtl/fwdmux.sv
// Forwarding mux select encodings shared by the EX-stage operand muxes
// and the hazard controller.
package fwdmux;

   typedef enum logic [1:0] {
      REGFILE = 2'b00,
      EXMEM   = 2'b01,
      MEMWB   = 2'b10
   } fwdmux_sel_t;

endpackage

// File: rtl/hazard_control_pkg.sv
// Shared types and helpers for hazard_control: capture FSM states,
// forwarding-source selection and saturating increment.
package hazard_control_pkg;

   typedef enum logic {
      CAP_IDLE = 1'b0,
      CAP_HELD = 1'b1
   } cap_state_t;

   // x0 is never forwarded; the younger EX/MEM result wins over MEM/WB.
   function automatic fwdmux::fwdmux_sel_t fwd_select(
      input logic [4:0] src,
      input logic [4:0] exmem_rd,
      input logic       exmem_ld,
      input logic [4:0] memwb_rd,
      input logic       memwb_ld
   );
      if (exmem_ld && (exmem_rd != 5'd0) && (exmem_rd == src)) return fwdmux::EXMEM;
      if (memwb_ld && (memwb_rd != 5'd0) && (memwb_rd == src)) return fwdmux::MEMWB;
      return fwdmux::REGFILE;
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] value);
      return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
   endfunction

endpackage

// File: rtl/resp_capture.sv
// Holds a cache response that arrives while the pipeline is frozen so the
// data survives until the pipeline advances; blocks re-access while held.
//
// state    | meaning
// CAP_IDLE | request and rdata pass straight through
// CAP_HELD | response captured, request gated off, rdata from buffer
module resp_capture
   import hazard_control_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned REQ_W = 1
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic [REQ_W-1:0] req,
   input  logic             resp,
   input  logic [XLEN-1:0]  rdata,
   input  logic             advance,
   output logic [REQ_W-1:0] req_gated,
   output logic [XLEN-1:0]  rdata_sel,
   output logic             held
);

   cap_state_t      state, state_nxt;
   logic [XLEN-1:0] hold_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= CAP_IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                          hold_data <= '0;
      else if ((state == CAP_IDLE) && resp && !advance) hold_data <= rdata;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         CAP_IDLE: if (resp && !advance) state_nxt = CAP_HELD;
         CAP_HELD: if (advance)          state_nxt = CAP_IDLE;
         default:                        state_nxt = CAP_IDLE;
      endcase
   end

   assign held      = (state == CAP_HELD);
   assign req_gated = (held || rst) ? '0 : req;
   assign rdata_sel = held ? hold_data : rdata;

endmodule

// File: rtl/hazard_control.sv
// Pipeline hazard/stall controller for the 5-stage RV32I core.
// Optional HAZARD_PERF_CNT_EN adds stall/bubble/flush saturating counters.
module hazard_control
   import hazard_control_pkg::*;
#(
   parameter int unsigned XLEN = 32
)
(
   input  logic                clk,
   input  logic                rst,
   input  logic [4:0]          ifid_rs1,
   input  logic [4:0]          ifid_rs2,
   input  logic [4:0]          idex_rs1,
   input  logic [4:0]          idex_rs2,
   input  logic [4:0]          idex_rd,
   input  logic                idex_dcache_read,
   input  logic                br_taken,
   input  logic [4:0]          exmem_rd,
   input  logic [4:0]          memwb_rd,
   input  logic                exmem_load_regfile,
   input  logic                memwb_load_regfile,
   input  logic                icache_read_req,
   input  logic                icache_resp,
   input  logic [XLEN-1:0]     icache_rdata,
   output logic                icache_read,
   output logic [XLEN-1:0]     if_rdata,
   input  logic                exmem_dcache_read,
   input  logic                exmem_dcache_write,
   input  logic                dcache_resp,
   input  logic [XLEN-1:0]     dcache_rdata,
   output logic                dcache_read,
   output logic                dcache_write,
   output logic [XLEN-1:0]     mem_rdata,
   output logic                load_pc,
   output control_itf::control ctrl
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]         stall_cnt,
   output logic [31:0]         bubble_cnt,
   output logic [31:0]         flush_cnt
`endif
);

   logic       if_held, mem_held;
   logic       stall_if, stall_mem, advance, lu;
   logic [1:0] d_req_gated;

   // A held response already satisfies its side, so it no longer stalls.
   assign stall_if  = icache_read_req & ~icache_resp & ~if_held;
   assign stall_mem = (exmem_dcache_read | exmem_dcache_write) & ~dcache_resp & ~mem_held;
   assign advance   = ~(stall_if | stall_mem);

   assign lu = idex_dcache_read & (idex_rd != 5'd0) &
               ((idex_rd == ifid_rs1) | (idex_rd == ifid_rs2));

   resp_capture #(.XLEN(XLEN), .REQ_W(1)) u_icap (
      .clk       (clk),
      .rst       (rst),
      .req       (icache_read_req),
      .resp      (icache_resp),
      .rdata     (icache_rdata),
      .advance   (advance),
      .req_gated (icache_read),
      .rdata_sel (if_rdata),
      .held      (if_held)
   );

   resp_capture #(.XLEN(XLEN), .REQ_W(2)) u_dcap (
      .clk       (clk),
      .rst       (rst),
      .req       ({exmem_dcache_write, exmem_dcache_read}),
      .resp      (dcache_resp),
      .rdata     (dcache_rdata),
      .advance   (advance),
      .req_gated (d_req_gated),
      .rdata_sel (mem_rdata),
      .held      (mem_held)
   );

   assign dcache_write = d_req_gated[1];
   assign dcache_read  = d_req_gated[0];

   always_comb begin
      ctrl    = '0;
      load_pc = 1'b0;
      if (rst) begin
         ctrl.pipe_rst_ifid  = 1'b1;
         ctrl.pipe_rst_idex  = 1'b1;
         ctrl.pipe_rst_exmem = 1'b1;
         ctrl.pipe_rst_memwb = 1'b1;
      end else begin
         ctrl.rs1mux_sel = fwd_select(idex_rs1, exmem_rd, exmem_load_regfile,
                                      memwb_rd, memwb_load_regfile);
         ctrl.rs2mux_sel = fwd_select(idex_rs2, exmem_rd, exmem_load_regfile,
                                      memwb_rd, memwb_load_regfile);
         if (advance) begin
            ctrl.pipe_load_idex  = 1'b1;
            ctrl.pipe_load_exmem = 1'b1;
            ctrl.pipe_load_memwb = 1'b1;
            if (br_taken) begin
               ctrl.pipe_load_ifid = 1'b1;
               ctrl.pipe_rst_ifid  = 1'b1;
               ctrl.pipe_rst_idex  = 1'b1;
               load_pc             = 1'b1;
            end else if (lu) begin
               // Hold PC and IF/ID, push a bubble into ID/EX.
               ctrl.pipe_rst_idex = 1'b1;
            end else begin
               ctrl.pipe_load_ifid = 1'b1;
               load_pc             = 1'b1;
            end
         end
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
         flush_cnt  <= '0;
      end else begin
         if (!advance)                     stall_cnt  <= sat_inc(stall_cnt);
         if (advance && !br_taken && lu)   bubble_cnt <= sat_inc(bubble_cnt);
         if (advance && br_taken)          flush_cnt  <= sat_inc(flush_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_hazard_control.sv
// Directed bench for hazard_control: reset, forwarding, load-use, branch
// flush and cross-stall response capture on both cache sides.
module tb_hazard_control;

   logic [4:0]  ifid_rs1, ifid_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd;
   logic        idex_dcache_read, br_taken, exmem_load_regfile, memwb_load_regfile;
   logic        icache_read_req, icache_resp, exmem_dcache_read, exmem_dcache_write, dcache_resp;
   logic [31:0] icache_rdata, dcache_rdata, if_rdata, mem_rdata;
   logic        icache_read, dcache_read, dcache_write, load_pc;
   control_itf::control ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          errors = 0;
   int          checks = 0;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt, bubble_cnt, flush_cnt;
   logic [31:0] base_stall, base_bubble, base_flush;
`endif

   always #5 clk = ~clk;

   hazard_control #(.XLEN(32)) dut (
      .clk(clk), .rst(rst),
      .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
      .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd),
      .idex_dcache_read(idex_dcache_read), .br_taken(br_taken),
      .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
      .exmem_load_regfile(exmem_load_regfile), .memwb_load_regfile(memwb_load_regfile),
      .icache_read_req(icache_read_req), .icache_resp(icache_resp),
      .icache_rdata(icache_rdata), .icache_read(icache_read), .if_rdata(if_rdata),
      .exmem_dcache_read(exmem_dcache_read), .exmem_dcache_write(exmem_dcache_write),
      .dcache_resp(dcache_resp), .dcache_rdata(dcache_rdata),
      .dcache_read(dcache_read), .dcache_write(dcache_write), .mem_rdata(mem_rdata),
      .load_pc(load_pc), .ctrl(ctrl)
`ifdef HAZARD_PERF_CNT_EN
      , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected: load_pc, loads {ifid,idex,exmem,memwb}, rsts {ifid,idex,exmem,memwb}
   task automatic chk_pipe(input string tag, input logic lpc, input logic [3:0] ld, input logic [3:0] rs);
      chk({tag, "_ld"}, 32'({load_pc, ctrl.pipe_load_ifid, ctrl.pipe_load_idex,
                              ctrl.pipe_load_exmem, ctrl.pipe_load_memwb}), 32'({lpc, ld}));
      chk({tag, "_rst"}, 32'({ctrl.pipe_rst_ifid, ctrl.pipe_rst_idex,
                               ctrl.pipe_rst_exmem, ctrl.pipe_rst_memwb}), 32'(rs));
   endtask

   task automatic clear_in();
      ifid_rs1 = '0; ifid_rs2 = '0; idex_rs1 = '0; idex_rs2 = '0; idex_rd = '0;
      exmem_rd = '0; memwb_rd = '0;
      idex_dcache_read = 1'b0; br_taken = 1'b0;
      exmem_load_regfile = 1'b0; memwb_load_regfile = 1'b0;
      icache_read_req = 1'b0; icache_resp = 1'b0; icache_rdata = '0;
      exmem_dcache_read = 1'b0; exmem_dcache_write = 1'b0;
      dcache_resp = 1'b0; dcache_rdata = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      clear_in();
      #2;
      chk_pipe("reset", 1'b0, 4'b0000, 4'b1111);
      chk("reset_rs1sel", 32'(ctrl.rs1mux_sel), 32'd0);
      tick(); tick();
      rst = 1'b0;
      #1;
      chk_pipe("idle", 1'b1, 4'b1111, 4'b0000);

      // Asynchronous reset in the middle of live requests
      icache_read_req = 1'b1; icache_resp = 1'b1;
      exmem_dcache_read = 1'b1; dcache_resp = 1'b1;
      idex_rs1 = 5'd5; exmem_rd = 5'd5; exmem_load_regfile = 1'b1;
      #1;
      chk("pre_rst_icache_read", 32'(icache_read), 32'd1);
      chk("pre_rst_dcache_read", 32'(dcache_read), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("rst_icache_read", 32'(icache_read), 32'd0);
      chk("rst_dcache_read", 32'(dcache_read), 32'd0);
      chk("rst_rs1sel", 32'(ctrl.rs1mux_sel), 32'd0);
      chk_pipe("rst_async", 1'b0, 4'b0000, 4'b1111);
      tick();
      rst = 1'b0;
      clear_in();
      #1;
      chk_pipe("post_rst", 1'b1, 4'b1111, 4'b0000);

      // Forwarding priority and x0 exclusion
      tick();
      idex_rs1 = 5'd5; exmem_rd = 5'd5; exmem_load_regfile = 1'b1;
      memwb_rd = 5'd5; memwb_load_regfile = 1'b1;
      #1 chk("fwd_exmem", 32'(ctrl.rs1mux_sel), 32'd1);
      exmem_rd = 5'd0;
      #1 chk("fwd_memwb", 32'(ctrl.rs1mux_sel), 32'd2);
      memwb_rd = 5'd0;
      #1 chk("fwd_x0", 32'(ctrl.rs1mux_sel), 32'd0);
      idex_rs2 = 5'd9; exmem_rd = 5'd9; exmem_load_regfile = 1'b0; memwb_rd = 5'd9;
      #1 chk("fwd_rs2_memwb", 32'(ctrl.rs2mux_sel), 32'd2);
      chk("fwd_rs1_none", 32'(ctrl.rs1mux_sel), 32'd0);

      // Load-use bubble, then the same ID instruction with the load in MEM
      tick(); clear_in();
      idex_dcache_read = 1'b1; idex_rd = 5'd7; ifid_rs2 = 5'd7;
      #1 chk_pipe("lu_bubble", 1'b0, 4'b0111, 4'b0100);
      tick(); clear_in();
      exmem_rd = 5'd7; exmem_load_regfile = 1'b1; ifid_rs2 = 5'd7;
      #1 chk_pipe("lu_after", 1'b1, 4'b1111, 4'b0000);
      tick(); clear_in();
      idex_dcache_read = 1'b1; idex_rd = 5'd0; ifid_rs1 = 5'd0;
      #1 chk_pipe("lu_x0", 1'b1, 4'b1111, 4'b0000);
      idex_rd = 5'd3; ifid_rs1 = 5'd3;
      #1 chk_pipe("lu_rs1", 1'b0, 4'b0111, 4'b0100);
      idex_dcache_read = 1'b0;
      #1 chk_pipe("lu_not_load", 1'b1, 4'b1111, 4'b0000);

      // Branch overrides load-use; stall overrides branch
      tick(); clear_in();
`ifdef HAZARD_PERF_CNT_EN
      base_flush = flush_cnt; base_bubble = bubble_cnt;
`endif
      br_taken = 1'b1; idex_dcache_read = 1'b1; idex_rd = 5'd7; ifid_rs2 = 5'd7;
      #1 chk_pipe("br_lu", 1'b1, 4'b1111, 4'b1100);
      tick(); clear_in();
      br_taken = 1'b1; exmem_dcache_read = 1'b1;
      #1 chk_pipe("br_stalled", 1'b0, 4'b0000, 4'b0000);
      tick(); clear_in();
      #1;
`ifdef HAZARD_PERF_CNT_EN
      chk("flush_cnt", flush_cnt, base_flush + 32'd1);
      chk("bubble_cnt_br", bubble_cnt, base_bubble);
`endif

      // I-side response captured while D-side stalls for 4 cycles
`ifdef HAZARD_PERF_CNT_EN
      base_stall = stall_cnt;
`endif
      exmem_dcache_read = 1'b1;
      icache_read_req = 1'b1; icache_resp = 1'b1; icache_rdata = 32'h00A0_0093;
      #1;
      chk("icap_c1_rdata", if_rdata, 32'h00A0_0093);
      chk("icap_c1_read", 32'(icache_read), 32'd1);
      chk_pipe("icap_c1", 1'b0, 4'b0000, 4'b0000);
      for (int c = 2; c <= 4; c++) begin
         tick();
         icache_resp = 1'b0; icache_rdata = 32'hDEAD_BEEF;
         #1;
         chk("icap_held_read", 32'(icache_read), 32'd0);
         chk("icap_held_rdata", if_rdata, 32'h00A0_0093);
         chk("icap_held_dread", 32'(dcache_read), 32'd1);
         chk_pipe("icap_held", 1'b0, 4'b0000, 4'b0000);
      end
      tick();
      dcache_resp = 1'b1; dcache_rdata = 32'h1234_5678;
      #1;
      chk_pipe("icap_release", 1'b1, 4'b1111, 4'b0000);
      chk("icap_release_mem", mem_rdata, 32'h1234_5678);
      chk("icap_release_if", if_rdata, 32'h00A0_0093);
      tick(); clear_in();
      icache_read_req = 1'b1; icache_resp = 1'b1; icache_rdata = 32'h0000_0013;
      #1;
      chk("icap_idle_read", 32'(icache_read), 32'd1);
      chk("icap_idle_rdata", if_rdata, 32'h0000_0013);
`ifdef HAZARD_PERF_CNT_EN
      chk("stall_cnt", stall_cnt, base_stall + 32'd4);
`endif

      // D-side response captured while I-side stalls
      tick(); clear_in();
      icache_read_req = 1'b1;
      exmem_dcache_write = 1'b1; dcache_resp = 1'b1; dcache_rdata = 32'hCAFE_0001;
      #1;
      chk("dcap_c1_write", 32'(dcache_write), 32'd1);
      chk_pipe("dcap_c1", 1'b0, 4'b0000, 4'b0000);
      tick();
      dcache_resp = 1'b0; dcache_rdata = 32'h0;
      #1;
      chk("dcap_held_write", 32'(dcache_write), 32'd0);
      chk("dcap_held_rdata", mem_rdata, 32'hCAFE_0001);
      chk_pipe("dcap_held", 1'b0, 4'b0000, 4'b0000);
      tick();
      icache_resp = 1'b1; icache_rdata = 32'h0000_0033;
      #1;
      chk_pipe("dcap_release", 1'b1, 4'b1111, 4'b0000);
      chk("dcap_release_mem", mem_rdata, 32'hCAFE_0001);
      tick(); clear_in();
      exmem_dcache_write = 1'b1; dcache_resp = 1'b1; dcache_rdata = 32'h0000_0055;
      #1;
      chk("dcap_idle_write", 32'(dcache_write), 32'd1);
      chk("dcap_idle_rdata", mem_rdata, 32'h0000_0055);

      // Simultaneous responses with advance: both pass through, neither holds
      tick(); clear_in();
      icache_read_req = 1'b1; icache_resp = 1'b1; icache_rdata = 32'h0000_0077;
      exmem_dcache_read = 1'b1; dcache_resp = 1'b1; dcache_rdata = 32'h0000_0088;
      #1;
      chk_pipe("both_resp", 1'b1, 4'b1111, 4'b0000);
      chk("both_if", if_rdata, 32'h0000_0077);
      chk("both_mem", mem_rdata, 32'h0000_0088);
      tick();
      icache_rdata = 32'h0000_0099; dcache_rdata = 32'h0000_00AA;
      #1;
      chk("both_next_iread", 32'(icache_read), 32'd1);
      chk("both_next_dread", 32'(dcache_read), 32'd1);
      chk("both_next_if", if_rdata, 32'h0000_0099);
      chk("both_next_mem", mem_rdata, 32'h0000_00AA);

      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
